// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard / stall / flush controller
//
// Watches the ID, EX and MEM stages of an in-order pipeline and drives the
// stage-register load enables and bubble (flush) controls.
//
// Handles, in priority order while running:
//   data-memory wait > halt > control redirect > load-use stall
// Also has a memory timeout (sticky mem_err, then halt) and a short drain
// period after a halt instruction before the core stops.
//
// Parameters
//   MEM_TIMEOUT  : cycles spent waiting in MEMWAIT before declaring a memory
//                  error and halting (must be >= 1)
//   DRAIN_CYCLES : cycles MEM/WB are allowed to retire after a halt is seen
//
// Optional feature
//   HAZ_PERF_EN  : when defined, stall_cycles / flush_count are saturating
//                  16-bit performance counters; otherwise both are tied to 0
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   rs1_ID, rs2_ID, uses_rs2_ID source operands of the instruction in ID
//   rd_EX, mem_rd_EX            destination / load flag of the EX instruction
//   branch_taken_EX, is_jr_EX   control redirect resolved in EX
//   hlt_EX                      halt instruction in EX
//   mem_req_MEM, dmem_ready     data-memory handshake for the MEM stage
//   pc_en, if_id_en, id_ex_en   stage-register load enables
//   if_id_flush, id_ex_flush    bubble insertion into IF/ID and ID/EX
//   halted, mem_err             registered status (mem_err is sticky)
//   stall_cycles, flush_count   performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        uses_rs2_ID,
    input  logic [4:0]  rd_EX,
    input  logic        mem_rd_EX,
    input  logic        branch_taken_EX,
    input  logic        is_jr_EX,
    input  logic        hlt_EX,
    input  logic        mem_req_MEM,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] MEMWAIT = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] HALT    = 2'd3;

    // Counters only need to reach their terminal value minus one.
    localparam int WW = (MEM_TIMEOUT  < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    logic [1:0]    state_reg, state_next;
    logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
    logic [DW-1:0] drain_cnt_reg, drain_cnt_next;
    logic          halted_reg, halted_next;
    logic          mem_err_reg, mem_err_next;

    logic load_use;
    logic redirect;
    logic mem_stall;

    // r0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use  = mem_rd_EX && (rd_EX != 5'd0) &&
                       ((rd_EX == rs1_ID) || (uses_rs2_ID && (rd_EX == rs2_ID)));
    assign redirect  = branch_taken_EX || is_jr_EX;
    assign mem_stall = mem_req_MEM && !dmem_ready;

    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        id_ex_en       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        halted_next    = halted_reg;
        mem_err_next   = mem_err_reg;

        case (state_reg)
            RUN: begin
                if (mem_stall) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    wait_cnt_next = '0;
                    state_next    = MEMWAIT;
                end else if (hlt_EX) begin
                    // Squash younger instructions; older ones keep retiring.
                    pc_en          = 1'b0;
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                    drain_cnt_next = '0;
                    if (DRAIN_CYCLES == 0) begin
                        halted_next = 1'b1;
                        state_next  = HALT;
                    end else begin
                        state_next  = DRAIN;
                    end
                end else if (redirect) begin
                    // A redirect also kills any load-use dependent in ID.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MEMWAIT: begin
                if (!dmem_ready) begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    if (wait_cnt_reg == WAIT_LAST) begin
                        mem_err_next = 1'b1;
                        halted_next  = 1'b1;
                        state_next   = HALT;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end else begin
                    state_next = RUN;
                end
            end
            DRAIN: begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (drain_cnt_reg == DRAIN_LAST) begin
                    halted_next = 1'b1;
                    state_next  = HALT;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
            end
            HALT: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
            end
            default: state_next = RUN;
        endcase

        // Keep the pipeline free-running and clean while reset is held.
        if (reset) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            halted_reg    <= 1'b0;
            mem_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            halted_reg    <= halted_next;
            mem_err_reg   <= mem_err_next;
        end
    end

    assign halted  = halted_reg;
    assign mem_err = mem_err_reg;

`ifdef HAZ_PERF_EN
    logic        stall_ev;
    logic        flush_ev;
    logic [15:0] stall_cycles_reg;
    logic [15:0] flush_count_reg;

    // Bubbles only originate from RUN when neither a memory wait nor a halt
    // takes precedence.
    assign stall_ev = !pc_en && (state_reg != HALT);
    assign flush_ev = (state_reg == RUN) && !mem_stall && !hlt_EX &&
                      (redirect || load_use);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (stall_ev && (stall_cycles_reg != 16'hFFFF))
                stall_cycles_reg <= stall_cycles_reg + 16'd1;
            if (flush_ev && (flush_count_reg != 16'hFFFF))
                flush_count_reg <= flush_count_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`else
    assign stall_cycles = 16'd0;
    assign flush_count  = 16'd0;
`endif

endmodule
